ifu_prefetch: RTL
=================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch buffer entries (power of two, at least 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL request an instruction-memory read.
REQ-006 imem_addr  output  32  SHALL carry the word-aligned read address, valid while imem_req=1.
REQ-007 imem_gnt  input  1  SHALL accept the request in any cycle where imem_req=1.
REQ-008 imem_rvalid  input  1  SHALL mark the read data valid; it arrives one or more cycles after imem_gnt.
REQ-009 imem_rdata  input  32  SHALL carry the instruction word.
REQ-010 redirect  input  1  SHALL flush the buffer and restart fetch (taken branch, jump, jr, syscall, eret).
REQ-011 redirect_pc  input  32  SHALL give the new fetch address, sampled when redirect=1.
REQ-012 stall  input  1  SHALL hold the buffer head and block pop (hazard hold from the decode stage).
REQ-013 out_valid  output  1  SHALL indicate that out_pc and out_ir hold a fetched instruction.
REQ-014 out_pc  output  32  SHALL give the address of the head instruction.
REQ-015 out_ir  output  32  SHALL give the head instruction word; it SHALL be 32'h0 (nop) when out_valid=0.

Function
REQ-016 The request FSM SHALL have three states: S_REQ (may issue), S_WAIT (one granted read outstanding), and S_DROP (outstanding read to be discarded).
REQ-017 At most one read SHALL be outstanding at any time.
REQ-018 In S_REQ, imem_req SHALL equal (count<DEPTH) and redirect=0, and imem_addr SHALL equal fetch_pc.
REQ-019 In S_REQ, imem_gnt with imem_req=1 SHALL move the FSM to S_WAIT and add 4 to fetch_pc (mod 2^32; wrap from 32'hFFFF_FFFC to 0).
REQ-020 In S_WAIT, imem_rvalid SHALL push {pending_addr, imem_rdata} into the tail and return the FSM to S_REQ.
REQ-021 In S_DROP, imem_rvalid SHALL discard the data and return the FSM to S_REQ.
REQ-022 In S_WAIT/S_DROP, imem_req SHALL be 0.
REQ-023 Redirect SHALL have priority over every other event and take effect at the same edge: empty the FIFO, set fetch_pc=redirect_pc, drop any pop and any push in that cycle.
REQ-024 Redirect in S_WAIT without imem_rvalid SHALL move the FSM to S_DROP; with imem_rvalid in the same cycle, the data SHALL be dropped and the FSM SHALL go to S_REQ.
REQ-025 Redirect in S_DROP SHALL keep S_DROP.
REQ-026 Redirect in S_REQ SHALL keep S_REQ, since imem_req is forced to 0.
REQ-027 Pop SHALL occur when out_valid=1, stall=0 and redirect=0.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, with correct head/tail advance.
REQ-029 A push to an empty FIFO SHALL make out_valid=1 the following cycle; there is no bypass.
REQ-030 Minimum latency SHALL be: redirect at cycle t, imem_req at t+1, rvalid at t+2 (one-cycle memory), out_valid with out_pc=redirect_pc at t+3.
REQ-031 Pointers SHALL be log2(DEPTH) bits wrapping naturally; count SHALL be log2(DEPTH)+1 bits.
REQ-032 Full (count=DEPTH) SHALL block new requests only; an already granted read always has room.
REQ-033 Low two bits of redirect_pc SHALL be forced to 0.

Reset
REQ-034 Reset SHALL put the FSM in S_REQ, set fetch_pc=RESET_PC and count/pointers to 0, and force imem_req=0, out_valid=0, out_pc=0, out_ir=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding read.
REQ-036 After reset, the memory side SHALL be presumed to also reset, so no drop is required.

Structure
REQ-037 FSM state encodings and the nop constant (32'h0) SHALL reside in the shared CPU package.
REQ-038 The buffer SHALL be one sub-module, prefetch_fifo (DEPTH x 64-bit, push/pop/flush/count); the FSM and fetch_pc SHALL stay in ifu_prefetch.

Verification
REQ-039 Reset release, one-cycle memory, stall=0 -> requests to 0x0,0x4,0x8...; out_pc 0x0 first valid at cycle 3; one instruction every 2 cycles.
REQ-040 stall=1 held for 20 cycles -> exactly 4 entries buffered, then imem_req=0; release stall -> out_pc 0x0,0x4,0x8,0xC in consecutive cycles.
REQ-041 redirect to 0x0000_0100 while S_WAIT, 3-cycle memory -> stale data discarded; next out_pc=0x100, out_ir=word at 0x100.
REQ-042 redirect coincident with imem_rvalid and with a pop -> neither pushed nor popped; out_valid=0 next cycle; fetch resumes at redirect_pc.
REQ-043 redirect_pc=32'hFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0 in order.
REQ-044 reset asserted for one cycle during S_DROP -> all outputs 0 immediately (asynchronous); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// Shared CPU definitions for the fetch unit: request FSM encodings,
// the nop word and a word-alignment helper.
package ifu_prefetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, instruction}, with push, pop and
// a flush that empties it in one edge.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   push_data,
    output logic [63:0]   head_data,
    output logic [AW:0]   count
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the top masks the head while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: single-outstanding memory request FSM feeding a
// small prefetch buffer, with redirect flush and decode-stage stall.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_pc_next;
    logic [31:0]  pending_addr;
    logic [31:0]  pending_addr_next;
    logic [AW:0]  count;
    logic [63:0]  head_data;
    logic         push;
    logic         pop;

    // Full only gates new requests; a granted read always finds a free slot.
    assign imem_req  = !reset && (state == S_REQ) && (count < FULL_COUNT) && !redirect;
    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head_data[63:32] : '0;
    assign out_ir    = out_valid ? head_data[31:0]  : NOP;
    assign pop       = out_valid && !stall && !redirect;

    always_comb begin
        state_next        = state;
        fetch_pc_next     = fetch_pc;
        pending_addr_next = pending_addr;
        push              = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_req && imem_gnt) begin
                    state_next        = S_WAIT;
                    fetch_pc_next     = fetch_pc + PC_STEP;
                    pending_addr_next = fetch_pc;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    push       = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
        // Redirect overrides any fetch_pc advance made in the same cycle.
        if (redirect) fetch_pc_next = align_word(redirect_pc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_REQ;
            fetch_pc     <= RESET_PC;
            pending_addr <= '0;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            pending_addr <= pending_addr_next;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({pending_addr, imem_rdata}),
        .head_data (head_data),
        .count     (count)
    );

endmodule
